// File: rtl/alu_pkg.sv
// Shared ALU package for the bit-serial arithmetic blocks.
// Contents:
//   ALU_WIDTH - default operand width of the ALU datapath
//   state_t   - 2-bit control state shared by the serial adder/subtractor
//               (IDLE=0, RUN=1, DONE=2)
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full-adder cell; the additive twin of the full-subtractor cell.
// Ports:
//   a, b  - operand bits
//   c     - carry in
//   sum   - a ^ b ^ c
//   cout  - majority(a, b, c)
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: sum/carry/overflow of a + b + cin, one bit per clock
// through a single full-adder cell.
// Ports:
//   clk, rst_n           - clock (rising edge), async active-low reset
//   in_valid/in_ready    - operand handshake (a, b, cin)
//   out_valid/out_ready  - result handshake (sum, carry, overflow, combine)
//   sum                  - (a + b + cin) mod 2^WIDTH
//   carry                - bit WIDTH of a + b + cin
//   overflow             - signed two's-complement overflow
//   combine              - {carry, sum}
//   busy                 - high while bits are being processed
// Result outputs only change on entry to DONE, so they hold the previous
// result through IDLE and RUN.
module serial_adder
  import alu_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic [WIDTH:0]   combine,
  output logic             busy
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  // Holds the WIDTH-1 sum bits produced so far; the final bit comes
  // straight from the cell on the last RUN cycle.
  logic [WIDTH-2:0] sreg;
  logic             cflop;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sum_next;

  full_adder_bit u_fa (
    .a    (areg[0]),
    .b    (breg[0]),
    .c    (cflop),
    .sum  (fa_s),
    .cout (fa_co)
  );

  // New sum bit enters from the MSB end; after WIDTH shifts bit 0 is at LSB.
  assign sum_next = {fa_s, sreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      combine   <= '0;
      areg      <= '0;
      breg      <= '0;
      sreg      <= '0;
      cflop     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            areg     <= a;
            breg     <= b;
            cflop    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          sreg  <= sum_next[WIDTH-1:1];
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          cflop <= fa_co;
          if (cnt == LAST) begin
            // cflop is the carry into the MSB, fa_co the carry out of it.
            sum       <= sum_next;
            carry     <= fa_co;
            overflow  <= cflop ^ fa_co;
            combine   <= {fa_co, sum_next};
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry;
  logic        overflow;
  logic [16:0] combine;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .combine   (combine),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, let the accept edge pass, then drop in_valid.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drop_valid", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [15:0] es, input logic ec,
                           input logic eo);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    check({tag, "_comb"}, 32'(combine), 32'({ec, es}));
  endtask

  initial begin : main
    int          lat;
    int          last_cyc;
    logic        seen;
    logic [15:0] ra, rb, es;
    logic        rc, ec, eo;
    logic [16:0] full;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_res("rst", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 0001 + FFFF
    send(16'h0001, 16'hFFFF, 1'b0);
    check("run_busy", 32'(busy), 32'd1);
    wait_valid(lat);
    check("lat1", 32'(lat), 32'd16);
    check_res("t1", 16'h0000, 1'b1, 1'b0);
    release_result();

    // 7FFF + 0001: signed overflow
    send(16'h7FFF, 16'h0001, 1'b0);
    wait_valid(lat);
    check("lat2", 32'(lat), 32'd16);
    check_res("t2", 16'h8000, 1'b0, 1'b1);
    release_result();

    // 1234 + 4321 + 1, with new operands offered during RUN
    send(16'h1234, 16'h4321, 1'b1);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    tick();
    check("run_in_ready", 32'(in_ready), 32'd0);
    wait_valid(lat);
    check("lat3", 32'(lat + 1), 32'd16);
    check_res("t3", 16'h5556, 1'b0, 1'b0);
    in_valid = 1'b0;
    release_result();

    // FFFF + FFFF + 1 with backpressure
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h0000FFFF);
      check("bp_carry", 32'(carry), 32'd1);
      tick();
    end
    check_res("t4", 16'hFFFF, 1'b1, 1'b0);
    release_result();

    // Reset mid-RUN
    send(16'h0F0F, 16'h0101, 1'b0);
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check_res("mrst", 16'h0000, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mrst_no_valid", 32'(seen), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd1);

    // 8000 + 8000
    send(16'h8000, 16'h8000, 1'b0);
    wait_valid(lat);
    check_res("t5", 16'h0000, 1'b1, 1'b1);
    release_result();

    // Back-to-back random vectors
    out_ready = 1'b1;
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
    a = ra; b = rb; cin = rc; in_valid = 1'b1;
    last_cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      es = full[15:0];
      ec = full[16];
      eo = (ra[15] == rb[15]) && (es[15] != ra[15]);
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!out_valid && lat < 40);
      if (!out_valid) begin
        check("b2b_timeout", 32'd0, 32'd1);
        break;
      end
      check_res("b2b", es, ec, eo);
      if (i > 0) check("b2b_period", 32'(cyc - last_cyc), 32'd18);
      last_cyc = cyc;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
      a = ra; b = rb; cin = rc;
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    tick();
    check("end_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
